// File: rtl/dcache_wb_pkg.sv
// dcache_wb_pkg: shared geometry defaults, access encodings and miss-FSM state type.
package dcache_wb_pkg;
    localparam int CACHE_NUM_LINES = 4;
    localparam int CACHE_LINE_SIZE = 64;
    localparam int ADDR_SIZE = 32;
    localparam int WD_SIZE = 32;
    localparam logic [2:0] MEM_ACCESS_BYTE = 3'd0;
    localparam logic [2:0] MEM_ACCESS_HALF = 3'd1;
    localparam logic [2:0] MEM_ACCESS_WORD = 3'd2;
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;
    typedef enum logic [2:0] {IDLE, WB, REFILL, FL_SCAN, FL_WB} dcache_state_t;
endpackage

// File: rtl/dcache_wb_array.sv
// dcache_wb_array: valid/dirty/tag/data storage with one combinational read port and one write port.
module dcache_array #(
    parameter int NUM_LINES = 4,
    parameter int LINE_BYTES = 64,
    parameter int TAG_W = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(NUM_LINES)-1:0]  idx_i,
    input  logic                          line_we_i,
    input  logic [TAG_W-1:0]              tag_i,
    input  logic [LINE_BYTES*8-1:0]       line_i,
    input  logic [LINE_BYTES-1:0]         be_i,
    input  logic [LINE_BYTES*8-1:0]       bdata_i,
    input  logic                          clr_dirty_i,
    input  logic                          inval_i,
    output logic                          valid_o,
    output logic                          dirty_o,
    output logic [TAG_W-1:0]              tag_o,
    output logic [LINE_BYTES*8-1:0]       line_o
);
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0] tag_q [NUM_LINES];
    logic [LINE_BYTES*8-1:0] data_q [NUM_LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o = tag_q[idx_i];
    assign line_o = data_q[idx_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (line_we_i) begin
                valid_q[idx_i] <= 1'b1;
                dirty_q[idx_i] <= 1'b0;
            end
            if (|be_i) dirty_q[idx_i] <= 1'b1;
            if (clr_dirty_i) dirty_q[idx_i] <= 1'b0;
            if (inval_i) begin
                valid_q[idx_i] <= 1'b0;
                dirty_q[idx_i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (line_we_i) begin
            tag_q[idx_i] <= tag_i;
            data_q[idx_i] <= line_i;
        end
        for (int b = 0; b < LINE_BYTES; b++)
            if (be_i[b]) data_q[idx_i][b*8+:8] <= bdata_i[b*8+:8];
    end
endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back/write-allocate data cache; hits in the request cycle,
// misses and flushes sequenced by a registered-output FSM.
module dcache_wb
    import dcache_wb_pkg::*;
#(
    parameter int NUM_LINES = CACHE_NUM_LINES,
    parameter int LINE_BYTES = CACHE_LINE_SIZE,
    parameter int ADDR_W = ADDR_SIZE,
    parameter int WD_W = WD_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [2:0]               cpu_size,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [WD_W-1:0]          cpu_wdata,
    output logic [WD_W-1:0]          cpu_rdata,
    output logic                     cpu_ready,
    output logic                     cpu_misalign,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_BYTES*8-1:0]  mem_wdata,
    input  logic                     mem_ready,
    input  logic [LINE_BYTES*8-1:0]  mem_rdata
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int LW = LINE_BYTES * 8;

    dcache_state_t state_q;
    logic [IDX_W:0] scan_q;
    logic pend_q;
    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] ridx, idx;
    logic [TAG_W-1:0] rtag, t;
    logic v, d, mis, hit, acc, ok, fl, scan_end, line_we, clr_dirty, inval;
    logic [LW-1:0] line, bdata;
    logic [LINE_BYTES-1:0] bm, be;
    logic [WD_W-1:0] rmask;

    assign off = cpu_addr[OFF_W-1:0];
    assign ridx = cpu_addr[OFF_W+:IDX_W];
    assign rtag = cpu_addr[ADDR_W-1-:TAG_W];
    assign fl = state_q == FL_SCAN || state_q == FL_WB;
    assign idx = fl ? scan_q[IDX_W-1:0] : ridx;
    assign scan_end = scan_q == (IDX_W+1)'(NUM_LINES);
    assign mis = (cpu_size == MEM_ACCESS_HALF && cpu_addr[0]) || (cpu_size == MEM_ACCESS_WORD && cpu_addr[1:0] != 2'b00);
    assign acc = state_q == IDLE && cpu_req;
    assign hit = v && t == rtag;
    assign ok = acc && !mis && hit;
    assign cpu_ready = acc && (mis || hit);
    assign cpu_misalign = acc && mis;

    always_comb begin
        bm = cpu_size == MEM_ACCESS_BYTE ? LINE_BYTES'(1) : cpu_size == MEM_ACCESS_HALF ? LINE_BYTES'(3) : LINE_BYTES'((1 << (WD_W / 8)) - 1);
        rmask = cpu_size == MEM_ACCESS_BYTE ? WD_W'(8'hFF) : cpu_size == MEM_ACCESS_HALF ? WD_W'(16'hFFFF) : '1;
        be = (ok && cpu_we) ? bm << off : '0;
        bdata = LW'(cpu_wdata) << {off, 3'b000};
        cpu_rdata = (ok && !cpu_we) ? WD_W'(line >> {off, 3'b000}) & rmask : '0;
        line_we = state_q == REFILL && mem_ready;
        clr_dirty = (state_q == WB || state_q == FL_WB) && mem_ready;
        inval = (state_q == FL_WB && mem_ready) || (state_q == FL_SCAN && !scan_end && !(v && d));
    end

    dcache_array #(.NUM_LINES(NUM_LINES), .LINE_BYTES(LINE_BYTES), .TAG_W(TAG_W)) u_array (
        .clk(clk), .rst(rst), .idx_i(idx), .line_we_i(line_we), .tag_i(rtag), .line_i(mem_rdata),
        .be_i(be), .bdata_i(bdata), .clr_dirty_i(clr_dirty), .inval_i(inval),
        .valid_o(v), .dirty_o(d), .tag_o(t), .line_o(line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            scan_q <= '0;
            pend_q <= 1'b0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            pend_q <= pend_q | flush;
            case (state_q)
                IDLE:
                    if (acc && !mis && !hit) begin
                        mem_req <= 1'b1;
                        mem_we <= v && d;
                        mem_addr <= {(v && d) ? t : rtag, ridx, {OFF_W{1'b0}}};
                        mem_wdata <= line;
                        state_q <= (v && d) ? WB : REFILL;
                    end else if ((flush || pend_q) && !cpu_req) begin
                        scan_q <= '0;
                        pend_q <= 1'b0;
                        state_q <= FL_SCAN;
                    end
                WB:
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        mem_addr <= {rtag, ridx, {OFF_W{1'b0}}};
                        state_q <= REFILL;
                    end
                REFILL:
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state_q <= IDLE;
                    end
                FL_SCAN:
                    if (scan_end) begin
                        flush_done <= 1'b1;
                        state_q <= IDLE;
                    end else if (v && d) begin
                        mem_req <= 1'b1;
                        mem_we <= 1'b1;
                        mem_addr <= {t, idx, {OFF_W{1'b0}}};
                        mem_wdata <= line;
                        state_q <= FL_WB;
                    end else scan_q <= scan_q + 1'b1;
                FL_WB:
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        scan_q <= scan_q + 1'b1;
                        state_q <= FL_SCAN;
                    end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed checks on a 4x64B and a 16x16B instance sharing one stimulus path,
// steered by sel.
module tb_dcache_wb;
    import dcache_wb_pkg::*;

    logic clk = 0, rst = 1, req = 0, we = 0, flush = 0, mrdy = 0, sel = 0;
    logic [2:0] size = MEM_ACCESS_WORD;
    logic [31:0] addr = '0, wdata = '0, ww;
    logic [511:0] mrd = '0;
    logic [31:0] rd_a, rd_b, ma_a, ma_b, rd, ma;
    logic rdy_a, rdy_b, mis_a, mis_b, fd_a, fd_b, mq_a, mq_b, mw_a, mw_b;
    logic rdy, mis, fd, mq, mw;
    logic [511:0] mwd_a;
    logic [127:0] mwd_b;
    logic [31:0] mwd;
    int n_chk = 0, n_pass = 0, fd_cnt = 0, xf_cnt = 0, xf0;

    always #5 clk = ~clk;

    dcache_wb u_a (
        .clk(clk), .rst(rst), .cpu_req(req && !sel), .cpu_we(we), .cpu_size(size), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_rdata(rd_a), .cpu_ready(rdy_a), .cpu_misalign(mis_a),
        .flush(flush && !sel), .flush_done(fd_a), .mem_req(mq_a), .mem_we(mw_a), .mem_addr(ma_a),
        .mem_wdata(mwd_a), .mem_ready(mrdy && !sel), .mem_rdata(mrd)
    );

    dcache_wb #(.NUM_LINES(16), .LINE_BYTES(16)) u_b (
        .clk(clk), .rst(rst), .cpu_req(req && sel), .cpu_we(we), .cpu_size(size), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_rdata(rd_b), .cpu_ready(rdy_b), .cpu_misalign(mis_b),
        .flush(flush && sel), .flush_done(fd_b), .mem_req(mq_b), .mem_we(mw_b), .mem_addr(ma_b),
        .mem_wdata(mwd_b), .mem_ready(mrdy && sel), .mem_rdata(mrd[127:0])
    );

    assign rd = sel ? rd_b : rd_a;
    assign rdy = sel ? rdy_b : rdy_a;
    assign mis = sel ? mis_b : mis_a;
    assign fd = sel ? fd_b : fd_a;
    assign mq = sel ? mq_b : mq_a;
    assign mw = sel ? mw_b : mw_a;
    assign ma = sel ? ma_b : ma_a;
    assign mwd = sel ? mwd_b[31:0] : mwd_a[31:0];

    always @(negedge clk) begin
        if (fd) fd_cnt++;
        if (mq && mrdy) xf_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] dv);
        req = 1;
        we = w;
        size = s;
        addr = a;
        wdata = dv;
    endtask

    task automatic resp(input string tag, input logic chk_rd, input logic [31:0] exp_rd);
        @(negedge clk);
        check({tag, "_rdy"}, rdy, 1);
        check({tag, "_mis"}, mis, 0);
        if (chk_rd) check({tag, "_rdata"}, rd, exp_rd);
        step();
        req = 0;
    endtask

    task automatic xfer(input string tag, input logic exp_we, input logic [31:0] exp_a, input logic [31:0] w0, output logic [31:0] wword);
        int n = 0;
        @(negedge clk);
        while (!mq && n < 50) begin
            step();
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, mq, 1);
        check({tag, "_we"}, mw, exp_we);
        check({tag, "_addr"}, ma, exp_a);
        wword = mwd;
        step();
        mrdy = 1;
        mrd = {{15{32'h5A5A5A5A}}, w0};
        @(negedge clk);
        check({tag, "_addr_held"}, ma, exp_a);
        step();
        mrdy = 0;
    endtask

    task automatic basic(input string p);
        drive(RD, MEM_ACCESS_WORD, 32'h1000, 0);
        @(negedge clk);
        check({p, "miss_rdy"}, rdy, 0);
        check({p, "miss_c0_req"}, mq, 0);
        step();
        xfer({p, "rf1000"}, 0, 32'h1000, 32'hDEADBEEF, ww);
        resp({p, "ld1000"}, 1, 32'hDEADBEEF);
        drive(RD, MEM_ACCESS_WORD, 32'h1000, 0);
        resp({p, "hit1000"}, 1, 32'hDEADBEEF);
        drive(WR, MEM_ACCESS_BYTE, 32'h1001, 32'h000000AB);
        resp({p, "stb1001"}, 0, 0);
        drive(RD, MEM_ACCESS_WORD, 32'h1000, 0);
        resp({p, "ld_merged"}, 1, 32'hDEADABEF);
        drive(RD, MEM_ACCESS_HALF, 32'h1002, 0);
        resp({p, "ldh1002"}, 1, 32'h0000DEAD);
        drive(RD, MEM_ACCESS_WORD, 32'h1100, 0);
        @(negedge clk);
        check({p, "conflict_rdy"}, rdy, 0);
        step();
        xfer({p, "wb1000"}, 1, 32'h1000, 0, ww);
        check({p, "wb_data"}, ww, 32'hDEADABEF);
        xfer({p, "rf1100"}, 0, 32'h1100, 32'h11110000, ww);
        resp({p, "ld1100"}, 1, 32'h11110000);
    endtask

    initial begin
        repeat (2) step();
        rst = 0;
        @(negedge clk);
        check("rst_rdy", rdy_a, 0);
        check("rst_mreq", mq_a, 0);
        check("rst_fd", fd_a, 0);
        check("rst_rdata", rd_a, 0);
        step();
        basic("a_");

        drive(RD, MEM_ACCESS_WORD, 32'h1002, 0);
        @(negedge clk);
        check("mis_rdy", rdy, 1);
        check("mis_flag", mis, 1);
        check("mis_rdata", rd, 0);
        check("mis_mreq", mq, 0);
        step();
        req = 0;
        @(negedge clk);
        check("mis_mreq_after", mq, 0);
        step();

        drive(WR, MEM_ACCESS_WORD, 32'h1100, 32'hCAFEF00D);
        resp("st1100", 0, 0);
        drive(WR, MEM_ACCESS_WORD, 32'h1040, 32'h12345678);
        @(negedge clk);
        check("st1040_miss", rdy, 0);
        step();
        xfer("rf1040", 0, 32'h1040, 32'h0, ww);
        resp("st1040", 0, 0);
        xf0 = xf_cnt;
        flush = 1;
        step();
        flush = 0;
        xfer("flwb0", 1, 32'h1100, 0, ww);
        check("flwb0_data", ww, 32'hCAFEF00D);
        xfer("flwb1", 1, 32'h1040, 0, ww);
        check("flwb1_data", ww, 32'h12345678);
        repeat (10) step();
        check("fl_done_cnt", fd_cnt, 1);
        check("fl_xfers", xf_cnt - xf0, 2);
        check("fl_idle_mreq", mq, 0);
        drive(RD, MEM_ACCESS_WORD, 32'h1100, 0);
        @(negedge clk);
        check("post_fl_miss", rdy, 0);
        step();
        xfer("rf_post_fl", 0, 32'h1100, 32'h77778888, ww);
        resp("ld_post_fl", 1, 32'h77778888);

        drive(RD, MEM_ACCESS_WORD, 32'h2000, 0);
        step();
        @(negedge clk);
        check("rst_rf_req", mq, 1);
        check("rst_rf_addr", ma, 32'h2000);
        step();
        rst = 1;
        req = 0;
        step();
        rst = 0;
        @(negedge clk);
        check("rst_mreq_drop", mq, 0);
        step();
        drive(RD, MEM_ACCESS_WORD, 32'h1100, 0);
        @(negedge clk);
        check("post_rst_miss", rdy, 0);
        step();
        xfer("rf_post_rst", 0, 32'h1100, 32'h0BADF00D, ww);
        resp("ld_post_rst", 1, 32'h0BADF00D);

        sel = 1;
        step();
        basic("b_");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
